mem_stage: RTL and testbench

//  Fourth pipeline stage of the c16 core, directly downstream of the execute stage.

---
 rtl/mem_stage_pkg.sv | 17 +
 rtl/mem_stage_wb_latch.sv | 45 ++++
 rtl/mem_stage.sv | 134 +++++++++++++
 tb/tb_mem_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the c16 memory stage: op encodings and FSM state codes.
package mem_stage_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'hF;
    localparam logic [3:0] OP_NOP  = 4'h2;
    localparam logic [3:0] OP_BRZ  = 4'h5;
    localparam logic [3:0] OP_BRNZ = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;

    typedef enum logic {
        StIdle,
        StLoadWait
    } state_e;

endpackage

// File: rtl/mem_stage_wb_latch.sv
// Writeback register: dest/value/pc update only when a result retires; we pulses for one cycle.
module wb_latch #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RA_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_upd,
    input  logic              i_we,
    input  logic [RA_W-1:0]   i_dest,
    input  logic [DATA_W-1:0] i_value,
    input  logic [15:0]       i_pc,
    output logic [RA_W-1:0]   o_dest,
    output logic [DATA_W-1:0] o_value,
    output logic              o_we,
    output logic [15:0]       o_pc
);

    logic [RA_W-1:0]   r_dest;
    logic [DATA_W-1:0] r_value;
    logic              r_we;
    logic [15:0]       r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dest  <= '0;
            r_value <= '0;
            r_we    <= 1'b0;
            r_pc    <= '0;
        end else begin
            r_we <= i_upd & i_we;
            if (i_upd) begin
                r_dest  <= i_dest;
                r_value <= i_value;
                r_pc    <= i_pc;
            end
        end
    end

    assign o_dest  = r_dest;
    assign o_value = r_value;
    assign o_we    = r_we;
    assign o_pc    = r_pc;

endmodule

// File: rtl/mem_stage.sv
// c16 memory stage: drives RAM port b for LD/ST, stalls upstream during load latency,
// and registers the register-file writeback.
import mem_stage_pkg::*;

module mem_stage #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned RA_W     = 3,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        x_op,
    input  logic [RA_W-1:0]   x_dest,
    input  logic [DATA_W-1:0] x_value,
    input  logic [DATA_W-1:0] x_store_data,
    input  logic [15:0]       x_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_out,
    output logic [RA_W-1:0]   wb_dest,
    output logic [DATA_W-1:0] wb_value,
    output logic              wb_we,
    output logic [15:0]       wb_pc
);

    localparam logic [RA_W-1:0] RA_DISCARD = RA_W'(7);

    state_e            r_state, w_state_nxt;
    logic [1:0]        r_wait_cnt, w_wait_nxt;
    logic [ADDR_W-1:0] r_ld_addr;
    logic [RA_W-1:0]   r_ld_dest;
    logic [15:0]       r_ld_pc;
    logic              w_ld_latch;
    logic [ADDR_W-1:0] w_x_addr;

    logic              w_wb_upd;
    logic              w_wb_we;
    logic [RA_W-1:0]   w_wb_dest;
    logic [DATA_W-1:0] w_wb_value;
    logic [15:0]       w_wb_pc;

    assign w_x_addr = ADDR_W'(x_value);

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_ld_latch  = 1'b0;
        w_wb_upd    = 1'b0;
        w_wb_we     = 1'b0;
        w_wb_dest   = x_dest;
        w_wb_value  = x_value;
        w_wb_pc     = x_pc;
        mem_addr    = w_x_addr;
        mem_wdata   = x_store_data;
        mem_wren    = 1'b0;
        stall_out   = 1'b0;
        case (r_state)
            StIdle: begin
                case (x_op)
                    OP_ADD, OP_SUB: begin
                        w_wb_upd = 1'b1;
                        w_wb_we  = (x_dest != RA_DISCARD);
                    end
                    OP_ST: mem_wren = 1'b1;
                    OP_LD: begin
                        w_state_nxt = StLoadWait;
                        w_wait_nxt  = 2'(LOAD_LAT - 1);
                        w_ld_latch  = 1'b1;
                    end
                    default: ;
                endcase
            end
            StLoadWait: begin
                stall_out = 1'b1;
                mem_addr  = r_ld_addr;
                if (r_wait_cnt != 2'd0) begin
                    w_wait_nxt = r_wait_cnt - 2'd1;
                end else begin
                    w_wb_upd    = 1'b1;
                    w_wb_we     = (r_ld_dest != RA_DISCARD);
                    w_wb_dest   = r_ld_dest;
                    w_wb_value  = mem_rdata;
                    w_wb_pc     = r_ld_pc;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        // Reset must quiesce the RAM port and the upstream stall immediately.
        if (reset) begin
            mem_wren  = 1'b0;
            stall_out = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_wait_cnt <= 2'd0;
            r_ld_addr  <= '0;
            r_ld_dest  <= '0;
            r_ld_pc    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_ld_latch) begin
                r_ld_addr <= w_x_addr;
                r_ld_dest <= x_dest;
                r_ld_pc   <= x_pc;
            end
        end
    end

    wb_latch #(
        .DATA_W(DATA_W),
        .RA_W  (RA_W)
    ) u_wb_latch (
        .clk    (clk),
        .reset  (reset),
        .i_upd  (w_wb_upd),
        .i_we   (w_wb_we),
        .i_dest (w_wb_dest),
        .i_value(w_wb_value),
        .i_pc   (w_wb_pc),
        .o_dest (wb_dest),
        .o_value(wb_value),
        .o_we   (wb_we),
        .o_pc   (wb_pc)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: two instances (LOAD_LAT=1 and 3), each with a RAM model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  x_op;
    logic [2:0]  x_dest;
    logic [15:0] x_value, x_store_data, x_pc;

    logic [15:0] m1_addr, m1_wdata, m1_rdata, wb1_value, wb1_pc;
    logic        m1_wren, stall1, wb1_we;
    logic [2:0]  wb1_dest;
    logic [15:0] m3_addr, m3_wdata, m3_rdata, wb3_value, wb3_pc;
    logic        m3_wren, stall3, wb3_we;
    logic [2:0]  wb3_dest;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(16), .ADDR_W(16), .RA_W(3), .LOAD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .x_op(x_op), .x_dest(x_dest), .x_value(x_value),
        .x_store_data(x_store_data), .x_pc(x_pc), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_wren(m1_wren), .mem_rdata(m1_rdata), .stall_out(stall1), .wb_dest(wb1_dest),
        .wb_value(wb1_value), .wb_we(wb1_we), .wb_pc(wb1_pc)
    );

    mem_stage #(.DATA_W(16), .ADDR_W(16), .RA_W(3), .LOAD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .x_op(x_op), .x_dest(x_dest), .x_value(x_value),
        .x_store_data(x_store_data), .x_pc(x_pc), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
        .mem_wren(m3_wren), .mem_rdata(m3_rdata), .stall_out(stall3), .wb_dest(wb3_dest),
        .wb_value(wb3_value), .wb_we(wb3_we), .wb_pc(wb3_pc)
    );

    // RAM models: write commits at the edge, read data is registered LOAD_LAT times.
    logic [15:0] ram1 [256];
    logic [15:0] ram3 [256];
    logic [15:0] q3 [3];

    always @(posedge clk) begin
        if (m1_wren) ram1[m1_addr[7:0]] <= m1_wdata;
        m1_rdata <= ram1[m1_addr[7:0]];
    end

    always @(posedge clk) begin
        if (m3_wren) ram3[m3_addr[7:0]] <= m3_wdata;
        q3[0] <= ram3[m3_addr[7:0]];
        q3[1] <= q3[0];
        q3[2] <= q3[1];
    end
    assign m3_rdata = q3[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] dest, input logic [15:0] val,
                         input logic [15:0] sdata);
        x_op         = op;
        x_dest       = dest;
        x_value      = val;
        x_store_data = sdata;
        x_pc         = x_pc + 16'd1;
    endtask

    task automatic idle(input int n);
        drive(4'h2, 3'd0, 16'h0, 16'h0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(4'h0, 3'd3, 16'h0005, 16'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL reset_stall act=%b req=0", stall1); end
            n_tests++; if (m1_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren act=%b req=0", m1_wren); end
            tick();
            n_tests++; if (wb1_we !== 1'b0) begin n_fail++; $display("FAIL reset_wb_we act=%b req=0", wb1_we); end
            n_tests++; if (wb1_value !== 16'h0) begin n_fail++; $display("FAIL reset_wb_value act=%h req=0000", wb1_value); end
            n_tests++; if (wb3_we !== 1'b0) begin n_fail++; $display("FAIL reset_wb3_we act=%b req=0", wb3_we); end
        end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_alu();
        drive(4'h0, 3'd3, 16'h1234, 16'h0);
        tick();
        n_tests++; if (wb1_we !== 1'b1) begin n_fail++; $display("FAIL add_we act=%b req=1", wb1_we); end
        n_tests++; if (wb1_dest !== 3'd3) begin n_fail++; $display("FAIL add_dest act=%0d req=3", wb1_dest); end
        n_tests++; if (wb1_value !== 16'h1234) begin n_fail++; $display("FAIL add_value act=%h req=1234", wb1_value); end
        drive(4'hF, 3'd7, 16'h0055, 16'h0);
        tick();
        n_tests++; if (wb1_we !== 1'b0) begin n_fail++; $display("FAIL sub_dest7_we act=%b req=0", wb1_we); end
        drive(4'hF, 3'd6, 16'hFFFE, 16'h0);
        tick();
        n_tests++; if (wb1_we !== 1'b1 || wb1_value !== 16'hFFFE) begin
            n_fail++; $display("FAIL sub_wb act=%b/%h req=1/fffe", wb1_we, wb1_value);
        end
        idle(1);
        n_tests++; if (wb1_we !== 1'b0) begin n_fail++; $display("FAIL wb_we_pulse act=%b req=0", wb1_we); end
    endtask

    task automatic test_store_load();
        logic [15:0] ld_pc;
        drive(4'h9, 3'd0, 16'h0010, 16'hBEEF);
        #1;
        n_tests++; if (m1_wren !== 1'b1) begin n_fail++; $display("FAIL st_wren act=%b req=1", m1_wren); end
        n_tests++; if (m1_addr !== 16'h0010 || m1_wdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL st_port act=%h/%h req=0010/beef", m1_addr, m1_wdata);
        end
        n_tests++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL st_stall act=%b req=0", stall1); end
        tick();
        n_tests++; if (wb1_we !== 1'b0) begin n_fail++; $display("FAIL st_wb_we act=%b req=0", wb1_we); end
        drive(4'h8, 3'd2, 16'h0010, 16'h0);
        ld_pc = x_pc;
        #1;
        n_tests++; if (m1_wren !== 1'b0 || m1_addr !== 16'h0010) begin
            n_fail++; $display("FAIL ld_port act=%b/%h req=0/0010", m1_wren, m1_addr);
        end
        tick();
        n_tests++; if (stall1 !== 1'b1 || wb1_we !== 1'b0) begin
            n_fail++; $display("FAIL ld_wait act=%b/%b req=1/0", stall1, wb1_we);
        end
        n_tests++; if (m1_addr !== 16'h0010 || m1_wren !== 1'b0) begin
            n_fail++; $display("FAIL ld_wait_port act=%h/%b req=0010/0", m1_addr, m1_wren);
        end
        tick();
        drive(4'h2, 3'd0, 16'h0, 16'h0);
        #1;
        n_tests++; if (wb1_we !== 1'b1 || wb1_dest !== 3'd2 || wb1_value !== 16'hBEEF) begin
            n_fail++; $display("FAIL ld_wb act=%b/%0d/%h req=1/2/beef", wb1_we, wb1_dest, wb1_value);
        end
        n_tests++; if (wb1_pc !== ld_pc) begin n_fail++; $display("FAIL ld_pc act=%h req=%h", wb1_pc, ld_pc); end
        n_tests++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL ld_done_stall act=%b req=0", stall1); end
        idle(5);
    endtask

    task automatic test_latency_sweep();
        drive(4'h9, 3'd0, 16'h0020, 16'hCAFE);
        tick();
        idle(1);
        drive(4'h8, 3'd1, 16'h0020, 16'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_tests++; if (stall3 !== 1'b1 || wb3_we !== 1'b0) begin
                n_fail++; $display("FAIL lat3_stall cyc=%0d act=%b/%b req=1/0", i, stall3, wb3_we);
            end
        end
        tick();
        drive(4'h0, 3'd4, 16'h0777, 16'h0);
        #1;
        n_tests++; if (wb3_we !== 1'b1 || wb3_dest !== 3'd1 || wb3_value !== 16'hCAFE) begin
            n_fail++; $display("FAIL lat3_wb act=%b/%0d/%h req=1/1/cafe", wb3_we, wb3_dest, wb3_value);
        end
        n_tests++; if (stall3 !== 1'b0) begin n_fail++; $display("FAIL lat3_end_stall act=%b req=0", stall3); end
        tick();
        n_tests++; if (wb3_we !== 1'b1 || wb3_dest !== 3'd4 || wb3_value !== 16'h0777) begin
            n_fail++; $display("FAIL lat3_add act=%b/%0d/%h req=1/4/0777", wb3_we, wb3_dest, wb3_value);
        end
        idle(5);
    endtask

    task automatic test_reset_mid_load();
        drive(4'h8, 3'd5, 16'h0010, 16'h0);
        tick();
        n_tests++; if (stall1 !== 1'b1) begin n_fail++; $display("FAIL rml_enter act=%b req=1", stall1); end
        reset = 1'b1;
        #1;
        n_tests++; if (stall1 !== 1'b0 || stall3 !== 1'b0) begin
            n_fail++; $display("FAIL rml_stall_gate act=%b/%b req=0/0", stall1, stall3);
        end
        tick();
        reset = 1'b0;
        drive(4'h2, 3'd0, 16'h0, 16'h0);
        #1;
        n_tests++; if (wb1_we !== 1'b0 || stall1 !== 1'b0 || wb1_value !== 16'h0) begin
            n_fail++; $display("FAIL rml_idle act=%b/%b/%h req=0/0/0000", wb1_we, stall1, wb1_value);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (wb1_we !== 1'b0 || wb3_we !== 1'b0 || stall1 !== 1'b0 || stall3 !== 1'b0) begin
                n_fail++; $display("FAIL rml_stale cyc=%0d act=%b%b%b%b req=0000", i, wb1_we, wb3_we, stall1, stall3);
            end
        end
    endtask

    task automatic test_nonmem_ops();
        logic [3:0] ops [4];
        ops = '{4'h5, 4'h6, 4'h2, 4'hA};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], 3'd3, 16'hFFFF, 16'h1111);
            #1;
            n_tests++; if (m1_wren !== 1'b0 || stall1 !== 1'b0) begin
                n_fail++; $display("FAIL op%h_port act=%b/%b req=0/0", ops[i], m1_wren, stall1);
            end
            tick();
            n_tests++; if (wb1_we !== 1'b0 || stall1 !== 1'b0 || stall3 !== 1'b0) begin
                n_fail++; $display("FAIL op%h_wb act=%b/%b/%b req=0/0/0", ops[i], wb1_we, stall1, stall3);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        x_op         = 4'h0;
        x_dest       = 3'd0;
        x_value      = 16'h0;
        x_store_data = 16'h0;
        x_pc         = 16'h0100;
        test_reset();
        test_alu();
        test_store_load();
        test_latency_sweep();
        test_reset_mid_load();
        test_nonmem_ops();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
